// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : video_pkg (package)
//  Purpose  : Shared types and helpers for the video source scheduler.
//             - sched_state_e : scheduler FSM states
//             - COLOR_W       : width of one colour component
//             - vs_active()   : tests a vsync sample against its polarity
//  Revision : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam int COLOR_W = 8;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_MUTE    = 2'd2
    } sched_state_e;

    // True when the vsync sample is at its active level.
    function automatic logic vs_active(input logic vs, input logic pol);
        return (vs == pol);
    endfunction

endpackage : video_pkg
`default_nettype wire

// File: rtl/video_src_sched_edge_det.sv
`default_nettype none
// ============================================================================
//  Module   : edge_det
//  Purpose  : Single-bit edge detector with a resettable previous-value
//             register. Edges are flagged combinationally in the cycle the
//             input differs from its registered previous value.
//  Ports    : clk_i    in  1  clock
//             rst_n_i  in  1  synchronous reset, active low
//             d_i      in  1  monitored signal
//             rise_o   out 1  d_i went 0 -> 1
//             fall_o   out 1  d_i went 1 -> 0
//  Revision : 1.0 - initial release
// ============================================================================
module edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise_o =  d_i & ~prev_q;
    assign fall_o = ~d_i &  prev_q;

endmodule : edge_det
`default_nettype wire

// File: rtl/video_src_sched.sv
`default_nettype none
// ============================================================================
//  Module   : video_src_sched
//  Purpose  : Selects which of two pixel sources feeds the DVI encoder.
//             Source changes are applied only at a vsync leading edge and
//             the RGB output is blanked to black for MUTE_FRAMES whole
//             frames around each switch; syncs and blank keep flowing.
//  Ports    : clk_i, rst_n_i            pixel clock, sync active-low reset
//             req_i, req_src_i          one-cycle source-change request
//             s0_*/s1_*                 source pixel/sync inputs
//             r_o/g_o/b_o, hsync_o,     registered selected pixel stream
//             vsync_o, blank_o
//             cur_src_o                 source currently routed
//             busy_o                    switch in progress
//             frame_cnt_o               vsync edges since reset (wraps)
//  Revision : 1.0 - initial release
// ============================================================================
module video_src_sched
    import video_pkg::*;
#(
    parameter logic        DEF_SRC     = 1'b0,
    parameter int unsigned MUTE_FRAMES = 2,
    parameter logic        VS_POL      = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               req_i,
    input  logic               req_src_i,
    input  logic [COLOR_W-1:0] s0_r_i,
    input  logic [COLOR_W-1:0] s0_g_i,
    input  logic [COLOR_W-1:0] s0_b_i,
    input  logic               s0_hsync_i,
    input  logic               s0_vsync_i,
    input  logic               s0_blank_i,
    input  logic [COLOR_W-1:0] s1_r_i,
    input  logic [COLOR_W-1:0] s1_g_i,
    input  logic [COLOR_W-1:0] s1_b_i,
    input  logic               s1_hsync_i,
    input  logic               s1_vsync_i,
    input  logic               s1_blank_i,
    output logic [COLOR_W-1:0] r_o,
    output logic [COLOR_W-1:0] g_o,
    output logic [COLOR_W-1:0] b_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               blank_o,
    output logic               cur_src_o,
    output logic               busy_o,
    output logic [15:0]        frame_cnt_o
);

    localparam logic [3:0] MUTE_INIT = 4'(MUTE_FRAMES - 1);
    localparam logic       SYNC_IDLE = ~VS_POL;

    sched_state_e       state_q, state_d;
    logic               cur_src_q, cur_src_d;
    logic               tgt_q, tgt_d;
    logic               pend_q, pend_d;
    logic               pend_src_q, pend_src_d;
    logic [3:0]         mute_cnt_q, mute_cnt_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d, blank_q, blank_d;

    logic sel_vsync;
    logic vs_rise, vs_fall, vs_edge;
    logic new_tgt, eff_pend, eff_pend_src, mute;

    // Frame edges are taken from whichever source is currently routed.
    assign sel_vsync = cur_src_q ? s1_vsync_i : s0_vsync_i;

    edge_det #(
        .RST_VAL (SYNC_IDLE)
    ) u_vs_edge (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (sel_vsync),
        .rise_o  (vs_rise),
        .fall_o  (vs_fall)
    );

    // Leading edge is the inactive->active transition for the chosen polarity.
    assign vs_edge = VS_POL ? vs_rise : vs_fall;

    // ------------------------------------------------------------------
    // Scheduler FSM and counters
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cur_src_d    = cur_src_q;
        tgt_d        = tgt_q;
        pend_d       = pend_q;
        pend_src_d   = pend_src_q;
        mute_cnt_d   = mute_cnt_q;
        frame_cnt_d  = frame_cnt_q + {15'd0, vs_edge};
        // A request arriving this cycle takes precedence (last request wins).
        new_tgt      = req_i ? req_src_i : tgt_q;
        eff_pend     = pend_q | req_i;
        eff_pend_src = req_i ? req_src_i : pend_src_q;

        case (state_q)
            ST_RUN: begin
                // A coincident vs_edge is deliberately not used here, so the
                // switch lands on the following frame boundary.
                if (req_i && (req_src_i != cur_src_q)) begin
                    tgt_d   = req_src_i;
                    state_d = ST_WAIT_VS;
                end
            end
            ST_WAIT_VS: begin
                tgt_d = new_tgt;
                if (new_tgt == cur_src_q) begin
                    state_d = ST_RUN;
                end else if (vs_edge) begin
                    cur_src_d  = new_tgt;
                    mute_cnt_d = MUTE_INIT;
                    state_d    = ST_MUTE;
                end
            end
            ST_MUTE: begin
                if (req_i) begin
                    pend_d     = 1'b1;
                    pend_src_d = req_src_i;
                end
                if (vs_edge) begin
                    if (mute_cnt_q == 4'd0) begin
                        pend_d = 1'b0;
                        if (eff_pend && (eff_pend_src != cur_src_q)) begin
                            tgt_d   = eff_pend_src;
                            state_d = ST_WAIT_VS;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        mute_cnt_d = mute_cnt_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output mux: driven from the next-state values so the mux and mute
    // change on the very vsync-edge pixel that causes the transition.
    // ------------------------------------------------------------------
    always_comb begin
        mute    = (state_d == ST_MUTE);
        hsync_d = cur_src_d ? s1_hsync_i : s0_hsync_i;
        vsync_d = cur_src_d ? s1_vsync_i : s0_vsync_i;
        blank_d = cur_src_d ? s1_blank_i : s0_blank_i;
        r_d     = cur_src_d ? s1_r_i     : s0_r_i;
        g_d     = cur_src_d ? s1_g_i     : s0_g_i;
        b_d     = cur_src_d ? s1_b_i     : s0_b_i;
        if (mute) begin
            r_d = '0;
            g_d = '0;
            b_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_RUN;
            cur_src_q   <= DEF_SRC;
            tgt_q       <= DEF_SRC;
            pend_q      <= 1'b0;
            pend_src_q  <= 1'b0;
            mute_cnt_q  <= 4'd0;
            frame_cnt_q <= 16'd0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            hsync_q     <= SYNC_IDLE;
            vsync_q     <= SYNC_IDLE;
            blank_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cur_src_q   <= cur_src_d;
            tgt_q       <= tgt_d;
            pend_q      <= pend_d;
            pend_src_q  <= pend_src_d;
            mute_cnt_q  <= mute_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            r_q         <= r_d;
            g_q         <= g_d;
            b_q         <= b_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            blank_q     <= blank_d;
        end
    end

    assign r_o         = r_q;
    assign g_o         = g_q;
    assign b_o         = b_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign blank_o     = blank_q;
    assign cur_src_o   = cur_src_q;
    assign busy_o      = (state_q != ST_RUN);
    assign frame_cnt_o = frame_cnt_q;

endmodule : video_src_sched
`default_nettype wire

// File: tb/tb_video_src_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_src_sched
//  Purpose  : Directed self-checking bench for video_src_sched. Two small
//             synthetic sources share one 16-pixel frame timing (vsync on
//             pixels 0-1, hsync on 4-5, blank from 12). A second instance
//             sees the vsync inverted and runs with VS_POL=0.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_src_sched;

    localparam int FL = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req, req_src, req_n, req_src_n;
    logic [7:0] s0_r, s0_g, s0_b, s1_r, s1_g, s1_b;
    logic       hs, vs, vs_inv, blank;

    logic [7:0]  r_o, g_o, b_o, r_n, g_n, b_n;
    logic        hsync_o, vsync_o, blank_o, cur_src_o, busy_o;
    logic        hsync_n, vsync_n, blank_n, cur_src_n, busy_n;
    logic [15:0] frame_cnt_o, frame_cnt_n;

    int total = 0;
    int bad   = 0;
    int pos;

    always #5 clk = ~clk;

    video_src_sched #(.DEF_SRC(1'b0), .MUTE_FRAMES(2), .VS_POL(1'b1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .req_src_i(req_src),
        .s0_r_i(s0_r), .s0_g_i(s0_g), .s0_b_i(s0_b),
        .s0_hsync_i(hs), .s0_vsync_i(vs), .s0_blank_i(blank),
        .s1_r_i(s1_r), .s1_g_i(s1_g), .s1_b_i(s1_b),
        .s1_hsync_i(hs), .s1_vsync_i(vs), .s1_blank_i(blank),
        .r_o(r_o), .g_o(g_o), .b_o(b_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .blank_o(blank_o), .cur_src_o(cur_src_o), .busy_o(busy_o),
        .frame_cnt_o(frame_cnt_o)
    );

    video_src_sched #(.DEF_SRC(1'b0), .MUTE_FRAMES(2), .VS_POL(1'b0)) dut_n (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req_n), .req_src_i(req_src_n),
        .s0_r_i(s0_r), .s0_g_i(s0_g), .s0_b_i(s0_b),
        .s0_hsync_i(hs), .s0_vsync_i(vs_inv), .s0_blank_i(blank),
        .s1_r_i(s1_r), .s1_g_i(s1_g), .s1_b_i(s1_b),
        .s1_hsync_i(hs), .s1_vsync_i(vs_inv), .s1_blank_i(blank),
        .r_o(r_n), .g_o(g_n), .b_o(b_n), .hsync_o(hsync_n), .vsync_o(vsync_n),
        .blank_o(blank_n), .cur_src_o(cur_src_n), .busy_o(busy_n),
        .frame_cnt_o(frame_cnt_n)
    );

    function automatic logic [7:0] exp_r(input logic src, input int p);
        return src ? 8'(8'hF0 - p) : 8'(p);
    endfunction

    function automatic logic [7:0] exp_g(input logic src, input int p);
        return src ? 8'(8'hC0 - p) : 8'(8'h40 + p);
    endfunction

    function automatic logic [7:0] exp_b(input logic src, input int p);
        return src ? 8'(8'h50 + p) : 8'(8'h80 + p);
    endfunction

    task automatic apply(input int p);
        s0_r   = exp_r(1'b0, p);
        s0_g   = exp_g(1'b0, p);
        s0_b   = exp_b(1'b0, p);
        s1_r   = exp_r(1'b1, p);
        s1_g   = exp_g(1'b1, p);
        s1_b   = exp_b(1'b1, p);
        vs     = (p < 2);
        vs_inv = ~(p < 2);
        hs     = (p >= 4) && (p < 6);
        blank  = (p >= 12);
    endtask

    // One clock: outputs are sampled 1 time unit after the edge, then the
    // sources advance to the next pixel.
    task automatic tick();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FL;
        apply(pos);
    endtask

    task automatic goto_pos(input int p);
        for (int n = 0; n < 2 * FL && pos != p; n++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; req_src = 1'b0; req_n = 1'b0; req_src_n = 1'b0;
        pos = 5;
        apply(pos);
        tick(); tick();
        chk("rst_r", r_o, 0);
        chk("rst_blank", blank_o, 1);
        chk("rst_vsync", vsync_o, 0);
        chk("rst_hsync", hsync_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_src", cur_src_o, 0);
        chk("rst_fc", frame_cnt_o, 0);
        chk("rst_vsync_n", vsync_n, 1);

        // Normal running from source 0
        rst_n = 1'b1;
        tick();
        chk("run_r", r_o, exp_r(1'b0, 7));
        chk("run_g", g_o, exp_g(1'b0, 7));
        chk("run_b", b_o, exp_b(1'b0, 7));
        goto_pos(0); tick();
        chk("fc1", frame_cnt_o, 1);
        chk("run_vsync", vsync_o, 1);
        goto_pos(0); tick();
        chk("fc2", frame_cnt_o, 2);

        // Request for the source already routed is ignored
        goto_pos(3); req = 1'b1; req_src = 1'b0; tick(); req = 1'b0;
        chk("same_busy", busy_o, 0);

        // Switch 0 -> 1 with two muted frames
        goto_pos(8); req = 1'b1; req_src = 1'b1; tick(); req = 1'b0;
        chk("sw_busy", busy_o, 1);
        chk("sw_src_wait", cur_src_o, 0);
        chk("sw_r_wait", r_o, exp_r(1'b0, 8));
        goto_pos(0); tick();
        chk("sw_src", cur_src_o, 1);
        chk("sw_mute_r", r_o, 0);
        chk("sw_mute_b", b_o, 0);
        chk("sw_vsync", vsync_o, 1);
        chk("fc3", frame_cnt_o, 3);
        goto_pos(4); tick();
        chk("mute_hsync", hsync_o, 1);
        chk("mute_r_mid", r_o, 0);
        goto_pos(12); tick();
        chk("mute_blank", blank_o, 1);
        goto_pos(0); tick();
        chk("mute2_r", r_o, 0);
        chk("mute2_busy", busy_o, 1);
        chk("fc4", frame_cnt_o, 4);
        goto_pos(0); tick();
        chk("unmute_busy", busy_o, 0);
        chk("unmute_r", r_o, exp_r(1'b1, 0));
        chk("unmute_g", g_o, exp_g(1'b1, 0));
        chk("fc5", frame_cnt_o, 5);

        // Cancel while waiting for vsync
        goto_pos(6); req = 1'b1; req_src = 1'b0; tick();
        chk("cancel_busy1", busy_o, 1);
        req_src = 1'b1; tick(); req = 1'b0;
        chk("cancel_busy0", busy_o, 0);
        chk("cancel_src", cur_src_o, 1);
        goto_pos(0); tick();
        chk("cancel_r", r_o, exp_r(1'b1, 0));
        chk("cancel_src2", cur_src_o, 1);
        chk("fc6", frame_cnt_o, 6);

        // Request during MUTE is held and replayed after the mute
        goto_pos(3); req = 1'b1; req_src = 1'b0; tick(); req = 1'b0;
        goto_pos(0); tick();
        chk("pend_src0", cur_src_o, 0);
        chk("pend_mute_r", r_o, 0);
        chk("fc7", frame_cnt_o, 7);
        goto_pos(9); req = 1'b1; req_src = 1'b1; tick(); req = 1'b0;
        chk("pend_busy", busy_o, 1);
        chk("pend_mute_r2", r_o, 0);
        goto_pos(0); tick();
        chk("pend_mute_r3", r_o, 0);
        chk("fc8", frame_cnt_o, 8);
        goto_pos(0); tick();
        chk("pend_wait_busy", busy_o, 1);
        chk("pend_wait_src", cur_src_o, 0);
        chk("pend_wait_r", r_o, exp_r(1'b0, 0));
        chk("fc9", frame_cnt_o, 9);
        goto_pos(0); tick();
        chk("pend_sw_src", cur_src_o, 1);
        chk("pend_sw_r", r_o, 0);
        goto_pos(0); tick();
        chk("pend_sw_r2", r_o, 0);
        goto_pos(0); tick();
        chk("pend_done_r", r_o, exp_r(1'b1, 0));
        chk("pend_done_busy", busy_o, 0);
        chk("fc12", frame_cnt_o, 12);

        // Request coincident with a vsync edge waits one more frame
        goto_pos(0); req = 1'b1; req_src = 1'b0; tick(); req = 1'b0;
        chk("coin_busy", busy_o, 1);
        chk("coin_src", cur_src_o, 1);
        chk("coin_r", r_o, exp_r(1'b1, 0));
        chk("fc13", frame_cnt_o, 13);
        goto_pos(0); tick();
        chk("coin_sw_src", cur_src_o, 0);
        chk("coin_sw_r", r_o, 0);
        goto_pos(0); tick();
        chk("coin_mute2_r", r_o, 0);
        goto_pos(0); tick();
        chk("coin_done_r", r_o, exp_r(1'b0, 0));
        chk("fc16", frame_cnt_o, 16);

        // Reset in the middle of a mute
        goto_pos(5); req = 1'b1; req_src = 1'b1; tick(); req = 1'b0;
        goto_pos(0); tick();
        chk("rm_src1", cur_src_o, 1);
        chk("fc17", frame_cnt_o, 17);
        goto_pos(7); rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rm_src", cur_src_o, 0);
        chk("rm_busy", busy_o, 0);
        chk("rm_blank", blank_o, 1);
        chk("rm_fc", frame_cnt_o, 0);
        chk("rm_r", r_o, 0);
        tick();
        chk("rm_resume_r", r_o, exp_r(1'b0, 8));
        chk("rm_resume_busy", busy_o, 0);
        goto_pos(0); tick();
        chk("rm_fc1", frame_cnt_o, 1);
        chk("rm_frame_r", r_o, exp_r(1'b0, 0));

        // Frame counter wrap
        goto_pos(3);
        force dut.frame_cnt_q = 16'hFFFF;
        tick();
        release dut.frame_cnt_q;
        chk("wrap_pre", frame_cnt_o, 16'hFFFF);
        goto_pos(0); tick();
        chk("wrap", frame_cnt_o, 16'h0000);

        // Active-low vsync instance switches on the falling edge
        goto_pos(1); req_n = 1'b1; req_src_n = 1'b1; tick(); req_n = 1'b0;
        chk("n_busy", busy_n, 1);
        goto_pos(2); tick();
        chk("n_no_rise_sw", cur_src_n, 0);
        chk("n_vsync_idle", vsync_n, 1);
        goto_pos(0); tick();
        chk("n_sw_src", cur_src_n, 1);
        chk("n_sw_vsync", vsync_n, 0);
        chk("n_sw_r", r_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_video_src_sched
`default_nettype wire
